// File: rtl/uart_rx_buffer_pkg.sv
// Shared constants for the UART receive buffer: character width, pointer sizing
// and the CPU status-word bit map.
package uart_buf_pkg;

  localparam int UART_DATA_W = 8;

  localparam int STAT_EMPTY_BIT   = 0;
  localparam int STAT_FULL_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;

  // ceil(log2(depth)), with a floor of 1 so a 2-deep FIFO still gets a pointer bit
  function automatic int ptr_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < depth) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser with a rising-edge pulse output; the reset value is a
// parameter so an input already high at reset release produces no pulse.
module sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1_r, s2_r, s3_r;

  // metastability chain plus one delay stage for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= RESET_VAL;
      s2_r <= RESET_VAL;
      s3_r <= RESET_VAL;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign pulse = s2_r & ~s3_r;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive FIFO between the baud-domain UART receiver and CPU polling registers.
// Optional irq output is enabled by defining UART_RX_BUF_IRQ_EN.
module uart_rx_buffer
  import uart_buf_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int WORD_SIZE     = 16,
  parameter int DATA_W        = UART_DATA_W,
  parameter int IRQ_THRESHOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic                 rd_en,
  input  logic                 clr_overrun,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [WORD_SIZE-1:0] count,
  output logic                 overrun
`ifdef UART_RX_BUF_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
  logic [PW:0]       count_r, count_next_s;
  logic [DATA_W-1:0] head_r, head_next_s;
  logic              empty_r, full_r, overrun_r, overrun_next_s;
  logic              push_s, pop_s, do_push_s, drop_s;

  sync_edge #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx_valid),
    .pulse (push_s)
  );

  // next-state for pointers, fill level, sticky flag and the head view
  always_comb begin
    pop_s          = rd_en & ~empty_r;
    do_push_s      = push_s & (~full_r | pop_s);
    drop_s         = push_s & full_r & ~pop_s;
    overrun_next_s = drop_s | (overrun_r & ~clr_overrun);
    rd_ptr_next_s  = rd_ptr_r;
    count_next_s   = count_r;
    head_next_s    = '0;
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    if (do_push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (!do_push_s && pop_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
    // a byte written this edge may itself become the new head
    if (count_next_s == '0) begin
      head_next_s = '0;
    end else if (do_push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = rx_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // byte storage, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // control and registered status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      head_r    <= '0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r  <= rd_ptr_next_s;
      count_r   <= count_next_s;
      head_r    <= head_next_s;
      empty_r   <= (count_next_s == '0);
      full_r    <= (count_next_s == DEPTH_C);
      overrun_r <= overrun_next_s;
    end
  end

`ifdef UART_RX_BUF_IRQ_EN
  localparam logic [PW:0] IRQ_TH_C = (PW+1)'(IRQ_THRESHOLD);
  logic irq_r;

  // interrupt tracks the same edge as count and overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (count_next_s >= IRQ_TH_C) | overrun_next_s;
    end
  end

  assign irq = irq_r;
`endif

  assign rd_data = {{(WORD_SIZE-DATA_W){1'b0}}, head_r};
  assign count   = {{(WORD_SIZE-PW-1){1'b0}}, count_r};
  assign empty   = empty_r;
  assign full    = full_r;
  assign overrun = overrun_r;

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side buffer between the UART receiver (`uart`) and the memory-mapped I/O in `memory`.
- Catches each byte-ready strobe from the receiver, which runs on the baud clock, and synchronises it into the system clock domain.
- Queues bytes in a FIFO so the CPU can drain bursts without losing characters.
- Presents the head byte zero-extended to WORD_SIZE, with empty/full/count/overrun status for CPU polling.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- WORD_SIZE, 16, width of the CPU-facing data and count words.
- DATA_W, 8, width of one UART character.
- IRQ_THRESHOLD, 8, fill level that raises irq; used only with UART_RX_BUF_IRQ_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  DATA_W  received byte from `uart`; held stable from the strobe until the next frame completes.
- rx_valid  input  1  new-data strobe from `uart`; baud-domain level/pulse, at least 1 clk wide.
- rd_en  input  1  CPU pop request, one pulse per byte.
- clr_overrun  input  1  clears the sticky overrun flag.
- rd_data  output  WORD_SIZE  {zeros, head byte}; 0 when empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds DEPTH bytes.
- count  output  WORD_SIZE  number of stored bytes, zero-extended.
- overrun  output  1  sticky flag: a byte was dropped.
- irq  output  1  present only with UART_RX_BUF_IRQ_EN.

Behaviour:
- Reset (asynchronous, active-low): rd/wr pointers = 0, count = 0, overrun = 0, rd_data = 0, empty = 1, full = 0, irq = 0. All synchroniser flops s1, s2, s3 reset to 1, so a rx_valid already high at reset release causes no spurious push.
- Synchroniser: s1 <= rx_valid, s2 <= s1, s3 <= s2. push = s2 & ~s3.
- Push latency: rx_valid high before clk edge k gives s1 = 1 at edge k and s2 = 1 at edge k+1. The byte is written at edge k+2, with rx_data sampled directly at that edge.
- Exactly one push per rising edge of rx_valid; a long-held high level pushes once.
- rd_data and empty are first-word-fall-through views of storage at rd_ptr; they update on the edge that changes contents or rd_ptr.
- pop = rd_en & ~empty. rd_en while empty is ignored: no pointer change, no error.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits internally.
- push & ~full: write at wr_ptr, wr_ptr+1, count+1.
- push & full & ~pop: byte dropped, overrun <= 1, storage unchanged.
- push & pop, not empty: both happen, count unchanged. This holds when full, since the pop frees a slot that same cycle: no overrun.
- push & rd_en when empty: push only; count becomes 1.
- overrun is sticky until clr_overrun. If an overrun event and clr_overrun coincide, set wins and overrun = 1.
- full = (count == DEPTH). empty = (count == 0).

Optional Feature:
Macro UART_RX_BUF_IRQ_EN.
- Defined: irq port exists, registered, irq <= (count_next >= IRQ_THRESHOLD) | overrun_next. irq changes on the same edge as count/overrun.
- Undefined: no irq port, no threshold comparator; IRQ_THRESHOLD is ignored.

Decomposition:
- Package uart_buf_pkg:
  - UART_DATA_W = 8.
  - Pointer-width constant function (clog2).
  - Status-word bit positions for the memory map: bit0 empty, bit1 full, bit2 overrun.
- Sub-module sync_edge: 3-flop synchroniser with parameter reset value (1 here) and a rising-edge pulse output. Reusable for the debounced buttons.

Test Plan:
- Reset then idle, rx_valid = 0 → empty = 1, count = 0, rd_data = 0x0000, overrun = 0. Assert reset low with rx_valid = 1 and release → no push.
- Strobe rx_valid (held 5 clks) with rx_data = 0x41 → exactly one push; empty falls on the 3rd clk edge after the rise; rd_data = 0x0041, count = 1. Pulse rd_en → empty = 1, count = 0.
- Push 0x01..0x10 (16 bytes) → full = 1, count = 16. Push 0x11 → overrun = 1, count = 16. Pop 16 times → reads 0x0001..0x0010 in order, no 0x0011.
- Full FIFO, push 0x55 coincident with pop → count stays 16, overrun stays 0, 0x55 becomes the last entry read. Separately, clr_overrun coincident with a dropped push → overrun = 1.
- Pointer wrap: 40 interleaved push/pop pairs with data = index → every read matches in order; count never exceeds 1. rd_en when empty → count stays 0.
- Async reset asserted mid-burst with count = 5 → all outputs return to reset values immediately, without a clock edge. With UART_RX_BUF_IRQ_EN and IRQ_THRESHOLD = 8: irq rises on the 8th push and falls when count drops to 7.
